// File: rtl/vga_output_module_if.sv
// Display-side signal bundle for the VGA output module: framebuffer pixel
// request/response plus the timed sync, blank and colour outputs.
interface vga_output_module_if;
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } screenXY;

    logic [2:0] color_in;
    screenXY    output_module_coords;
    logic       new_frame;
    logic       hsync;
    logic       vsync;
    logic       blank_n;
    logic [2:0] vga_rgb;

    modport master (
        input  color_in,
        output output_module_coords, new_frame, hsync, vsync, blank_n, vga_rgb
    );

    modport slave (
        output color_in,
        input  output_module_coords, new_frame, hsync, vsync, blank_n, vga_rgb
    );
endinterface

// File: rtl/vga_output_module.sv
// VGA timing generator: half-rate pixel enable, h/v counters exposed as the
// framebuffer request, display outputs registered one pixel behind them.
module vga_output_module #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input logic                 Clk,
    input logic                 Reset_n,
    vga_output_module_if.master vga
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    // Sums are done in 32-bit int and only then narrowed to counter width.
    localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
    localparam logic [9:0] H_VEND = 10'(H_VIS);
    localparam logic [9:0] V_VEND = 10'(V_VIS);
    localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);

    logic       phase;
    logic       pix_en;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       hs_raw;
    logic       vs_raw;
    logic       vis_raw;
    logic       nf_hit;

    // Phase is 0 out of reset, so the first pix_en lands on the second edge.
    assign pix_en = phase;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            phase <= 1'b0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            phase <= ~phase;
            if (pix_en) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
            end
        end
    end

    always_comb begin
        hs_raw  = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        vs_raw  = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        vis_raw = (h_cnt < H_VEND) && (v_cnt < V_VEND);
        // Counters sit at (0, VS_BEG) for two clocks; fire only on the off-phase one.
        nf_hit  = !pix_en && (h_cnt == '0) && (v_cnt == VS_BEG);
    end

    assign vga.output_module_coords.x = h_cnt;
    assign vga.output_module_coords.y = v_cnt;

    // Colour for the current coordinates has had one clock to settle by the
    // next pix_en, so it is captured together with that pixel's sync/blank.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vga.hsync     <= 1'b1;
            vga.vsync     <= 1'b1;
            vga.blank_n   <= 1'b0;
            vga.vga_rgb   <= 3'b000;
            vga.new_frame <= 1'b0;
        end else begin
            vga.new_frame <= nf_hit;
            if (pix_en) begin
                vga.hsync   <= hs_raw;
                vga.vsync   <= vs_raw;
                vga.blank_n <= vis_raw;
                vga.vga_rgb <= vis_raw ? vga.color_in : 3'b000;
            end
        end
    end
endmodule

// File: tb/tb_vga_output_module.sv
// Scoreboard bench for vga_output_module on a shrunken raster so whole
// frames, mid-frame reset and colour patterns fit in a short run.
module tb_vga_output_module;
    localparam int H_VIS = 8, H_FP = 2, H_SYNC = 3, H_BP = 2;
    localparam int V_VIS = 6, V_FP = 2, V_SYNC = 2, V_BP = 2;
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FR    = H_TOT * V_TOT * 2;
    localparam int NF_Y  = V_VIS + V_FP;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       bl;
        logic [2:0] rgb;
    } pix_t;

    logic Clk;
    logic Reset_n;
    vga_output_module_if vif();

    vga_output_module #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .vga(vif)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int   checks = 0;
    int   errors = 0;
    int   mode;
    logic mph;
    int   mx, my;
    pix_t sb[$];
    pix_t cur;
    int   nf_cnt, hs_low, vs_low, vis_cnt, rgb1, rgb7;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] mcol(input int x, input int y);
        case (mode)
            0:       return (x == y) ? 3'b001 : 3'b000;
            1:       return 3'b111;
            default: return 3'((x * 3 + y * 5 + 1) & 7);
        endcase
    endfunction

    function automatic pix_t exp_pix(input int x, input int y);
        pix_t p;
        p.hs  = !((x >= H_VIS + H_FP) && (x < H_VIS + H_FP + H_SYNC));
        p.vs  = !((y >= V_VIS + V_FP) && (y < V_VIS + V_FP + V_SYNC));
        p.bl  = (x < H_VIS) && (y < V_VIS);
        p.rgb = p.bl ? mcol(x, y) : 3'b000;
        return p;
    endfunction

    task automatic clr_stats();
        nf_cnt = 0; hs_low = 0; vs_low = 0; vis_cnt = 0; rgb1 = 0; rgb7 = 0;
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_x"},  vif.output_module_coords.x, 0);
        chk({tag, "_y"},  vif.output_module_coords.y, 0);
        chk({tag, "_hs"}, vif.hsync, 1);
        chk({tag, "_vs"}, vif.vsync, 1);
        chk({tag, "_bl"}, vif.blank_n, 0);
        chk({tag, "_rgb"}, vif.vga_rgb, 0);
        chk({tag, "_nf"}, vif.new_frame, 0);
    endtask

    task automatic model_reset();
        mph = 1'b0; mx = 0; my = 0;
        sb.delete();
        cur = '{hs: 1'b1, vs: 1'b1, bl: 1'b0, rgb: 3'b000};
        vif.color_in = mcol(mx, my);
    endtask

    // One clock: expectation for the pixel being retired is queued before the
    // edge, then everything is compared 1 time unit after it.
    task automatic tick();
        logic pix;
        logic enf;
        pix = mph;
        if (pix) sb.push_back(exp_pix(mx, my));
        enf = !pix && (mx == 0) && (my == NF_Y);
        @(posedge Clk);
        #1;
        mph = ~mph;
        if (pix) begin
            if (mx == H_TOT - 1) begin
                mx = 0;
                my = (my == V_TOT - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
            if (sb.size() == 0) chk("sb_empty", 1, 0);
            else cur = sb.pop_front();
            if (!vif.hsync) hs_low++;
            if (!vif.vsync) vs_low++;
            if (vif.blank_n) vis_cnt++;
            if (vif.vga_rgb == 3'b001) rgb1++;
            if (vif.vga_rgb == 3'b111) rgb7++;
        end
        if (vif.new_frame) nf_cnt++;
        chk("x", vif.output_module_coords.x, mx);
        chk("y", vif.output_module_coords.y, my);
        chk("nf", vif.new_frame, enf);
        chk("hs", vif.hsync, cur.hs);
        chk("vs", vif.vsync, cur.vs);
        chk("bl", vif.blank_n, cur.bl);
        chk("rgb", vif.vga_rgb, cur.rgb);
        vif.color_in = mcol(mx, my);
    endtask

    initial begin
        Reset_n = 1'b0;
        mode = 0;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        rst_chk("rst0");
        @(negedge Clk);
        Reset_n = 1'b1;

        // Diagonal pattern: lit only where x==y inside the visible area.
        clr_stats();
        repeat (FR) tick();
        chk("f0_nf", nf_cnt, 1);
        chk("f0_hslow", hs_low, H_SYNC * V_TOT);
        chk("f0_vslow", vs_low, V_SYNC * H_TOT);
        chk("f0_vis", vis_cnt, H_VIS * V_VIS);
        chk("f0_diag", rgb1, (H_VIS < V_VIS) ? H_VIS : V_VIS);

        // Constant white: lit exactly on visible pixels.
        mode = 1;
        vif.color_in = mcol(mx, my);
        clr_stats();
        repeat (FR) tick();
        chk("f1_nf", nf_cnt, 1);
        chk("f1_vis", vis_cnt, H_VIS * V_VIS);
        chk("f1_white", rgb7, H_VIS * V_VIS);

        // Coordinate-dependent colours.
        mode = 2;
        vif.color_in = mcol(mx, my);
        clr_stats();
        repeat (FR) tick();
        chk("f2_nf", nf_cnt, 1);

        // Mid-frame reset, applied between clock edges.
        begin
            int n;
            n = 0;
            while (!(mx == 5 && my == 4) && n < 2 * FR) begin
                tick();
                n++;
            end
            chk("reach_5_4", n < 2 * FR, 1);
        end
        #2;
        Reset_n = 1'b0;
        #1;
        rst_chk("rst1");
        @(negedge Clk);
        @(negedge Clk);
        #1;
        rst_chk("rst1_hold");
        Reset_n = 1'b1;
        model_reset();
        clr_stats();
        repeat (FR) tick();
        chk("f3_nf", nf_cnt, 1);
        chk("f3_vis", vis_cnt, H_VIS * V_VIS);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_output_module.md
VGA_OUTPUT_MODULE -- requirements
Module: vga_output_module

Interface
REQ-001 SHALL have parameter H_VIS, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_VIS, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33, vertical porch and sync widths in lines.
REQ-005 SHALL have port Clk, input, 1, system clock (50 MHz); the only clock.
REQ-006 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port color_in, input, 3, framebuffer pixel colour, {R,G,B}, valid one Clk after coordinates change.
REQ-008 SHALL have port output_module_coords, output, screenXY (x,y each 10 bits), current pixel request.
REQ-009 SHALL have port new_frame, output, 1, one-Clk pulse at vertical sync start.
REQ-010 SHALL have ports hsync and vsync, output, 1 each, active-low sync.
REQ-011 SHALL have port blank_n, output, 1, high while the displayed pixel is visible.
REQ-012 SHALL have port vga_rgb, output, 3, displayed colour {R,G,B}.

Function
REQ-013 SHALL generate pix_en, high every second Clk cycle, starting with the first Clk edge after reset release; all counters advance only on pix_en.
REQ-014 SHALL keep h_cnt in 0..H_TOT-1, where H_TOT = H_VIS+H_FP+H_SYNC+H_BP (800); it wraps to 0 after H_TOT-1.
REQ-015 SHALL keep v_cnt in 0..V_TOT-1, where V_TOT = V_VIS+V_FP+V_SYNC+V_BP (525); it increments only on the pix_en at which h_cnt wraps, and wraps to 0 after V_TOT-1.
REQ-016 SHALL drive output_module_coords.x = h_cnt and .y = v_cnt directly from the counter registers, including in blanking.
REQ-017 SHALL delay display outputs by exactly one pixel period relative to the coordinates, so colour for pixel (x,y) appears with the sync and blank state of (x,y).
REQ-018 SHALL assert raw hsync low for H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC (656..751), and drive the registered hsync output from it delayed per REQ-017.
REQ-019 SHALL assert raw vsync low for V_VIS+V_FP <= v_cnt < V_VIS+V_FP+V_SYNC (490..491), and drive the registered vsync output from it delayed per REQ-017.
REQ-020 SHALL set raw visible = (h_cnt < H_VIS) && (v_cnt < V_VIS); blank_n SHALL be raw visible delayed per REQ-017.
REQ-021 SHALL update vga_rgb on pix_en to color_in when the delayed visible is high, and to 3'b000 otherwise.
REQ-022 SHALL pulse new_frame high for exactly one Clk, on the Clk following the pix_en at which v_cnt becomes V_VIS+V_FP with h_cnt = 0; exactly one pulse per frame.
REQ-023 SHALL keep all display outputs constant between pix_en pulses.
REQ-024 SHALL make counter comparisons at least 10 bits wide; parameter sums SHALL NOT truncate for totals up to 1023.

Reset
REQ-025 SHALL, while Reset_n is low, immediately force h_cnt=0, v_cnt=0, pix_en phase=0, hsync=1, vsync=1, blank_n=0, vga_rgb=0, new_frame=0, and coords=(0,0).
REQ-026 SHALL, if Reset_n is asserted mid-frame, abort the frame with no partial new_frame pulse and restart at (0,0) after release.
REQ-027 SHALL be released synchronously: the first pix_en occurs on the second Clk edge after Reset_n rises.

Verification
REQ-028 SHALL be verified by running a full frame: 800*525*2 = 840000 Clk per frame; hsync low for 96 pixels (192 Clk) per line; vsync low for 2 lines (1600 pixels) per frame.
REQ-029 SHALL be verified by new_frame checks: exactly one pulse per 840000 Clk, asserted at coords (0,490) plus one Clk.
REQ-030 SHALL be verified with a colour model returning 3'b001 when x==y: vga_rgb==3'b001 only on displayed pixels (k,k), k<480; 0 elsewhere and always 0 when blank_n=0.
REQ-031 SHALL be verified at boundaries: coords (639,y) are displayed visible, (640,y) are displayed blank; coords (799,524) wrap to (0,0) on the next pix_en.
REQ-032 SHALL be verified by asserting Reset_n low at coords (300,200): outputs reach reset values without any Clk edge; after release, coords=(0,0) and the (1,0) update lands on Clk edge 2.
REQ-033 SHALL be verified with color_in held at 3'b111 throughout: vga_rgb==3'b111 exactly while blank_n=1, giving 640*480 displayed pixels per frame.
